mb8_arb: RTL and testbench
==========================

Name: mb8_arb

Overview:
- N-requester arbiter and sequencer for the shared 8-bit single-port SPRAM memory bus: 17-bit address, 8-bit data, 128 KB.
- Sits between the eForth core, the UART loader and the debug port on one side, and the SPRAM block on the other.
- Grants at most one access per cycle (round-robin), drives the memory-side write enable, address and write data, and returns read data with a per-requester acknowledge.

Parameters:
- N, 2, number of requesters (2..4).
- DSZ, 8, data width.
- ASZ, 17, address width (20 - clog2(DSZ)).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  N  per-requester access request (level).
- we  input  N  per-requester write enable; sampled with req.
- ai  input  N*ASZ  packed addresses; requester k occupies bits [k*ASZ +: ASZ].
- vi  input  N*DSZ  packed write data; requester k occupies bits [k*DSZ +: DSZ].
- gnt  output  N  one-hot pulse: this requester's access is being issued this cycle.
- ack  output  N  one-hot pulse: access complete; rdata is valid for reads.
- rdata  output  DSZ  read data (shared by all requesters).
- mem_we  output  1  memory write enable.
- mem_ai  output  ASZ  memory address.
- mem_vi  output  DSZ  memory write data.
- mem_vo  input  DSZ  memory read data; valid one cycle after the address is presented.

Behaviour:
- Reset (asynchronous, while rst_n=0):
  - gnt=0, ack=0, mem_we=0, mem_ai=0, mem_vi=0.
  - Round-robin pointer last=N-1, so requester 0 wins first.
  - Any in-flight ack is discarded; no ack is ever issued for an access begun before reset.
- Cycle t (arbitration, combinational):
  - eligible = req & ~gnt. The requester issued in cycle t is excluded in cycle t+1, which prevents a double grant on a request that has not yet been lowered.
  - Winner w = first eligible index scanning last+1, last+2, … modulo N.
- Rising edge ending cycle t, if eligible != 0:
  - mem_we <= we[w]; mem_ai <= ai[w]; mem_vi <= vi[w]; gnt <= one-hot(w); last <= w.
  - Otherwise: gnt <= 0, mem_we <= 0; mem_ai and mem_vi hold their values.
- Cycle t+1 (issue cycle):
  - gnt[w]=1 and the memory sees the access.
  - The requester must drop req, or present its next request, from cycle t+2.
  - The requester must hold ai, we and vi stable from its req rising until gnt.
- Cycle t+2 (complete):
  - ack[w]=1 (registered copy of gnt).
  - rdata = mem_vo, combinational; meaningful only for reads.
  - Write ack is issued with identical timing.
- Throughput and latency:
  - One access per cycle when two or more requesters alternate.
  - A single requester gets at most one access every 2 cycles.
  - Latency from req to ack is 2 cycles; from req to gnt is 1 cycle.
- Simultaneous requests: strict rotation, no starvation. Worst-case wait for any requester is N-1 issued accesses.
- mem_we is never high outside a gnt cycle.
- rdata when no ack is asserted is don't-care; the bench must not check it.
- Out-of-range requester indices do not exist (N is fixed); a req bit above N is ignored by construction.

Optional Feature:
- MB8_ARB_PRIO_EN defined:
  - Requester 0 (the eForth core) has fixed highest priority. Whenever it is eligible it wins, and last is not updated.
  - The remaining requesters rotate round-robin among themselves.
  - Requester 0 can starve the others; the system relies on core idle cycles.
- MB8_ARB_PRIO_EN undefined: pure round-robin as described under Behaviour.

Test Plan:
- Reset: hold rst_n=0 with req=2'b11. Expect gnt=0, ack=0, mem_we=0, mem_ai=0. Release rst_n: requester 0 is granted first (gnt=2'b01 one cycle after release).
- Single read: preload mem[0x00123]=0xA5; req[0]=1, we=0, ai=0x00123 for one cycle. Expect gnt=2'b01 at t+1 with mem_ai=0x00123 and mem_we=0; ack=2'b01 and rdata=0xA5 at t+2.
- Write then read: requester 1 writes 0x3C to 0x1FFFF (top address), then reads it back. Expect mem_we=1 only in the write's gnt cycle; read ack returns rdata=0x3C.
- Contention: req=2'b11 held continuously. Expect gnt alternating 01,10,01,10 and ack following one cycle later; each requester is acked every 2 cycles.
- Back-to-back same requester: req[0] held high for 4 cycles. Expect gnt[0]=1 on alternate cycles only, never in consecutive cycles.
- Mid-flight reset: assert rst_n=0 in the cycle gnt[1]=1. Expect ack to stay 0 and no mem_we after release until a new request arrives. With MB8_ARB_PRIO_EN, req=2'b11 continuously gives gnt=01 on every eligible cycle.

Source files
------------

// File: rtl/mb8_arb_if.sv
// mb8_arb_if: requester-side and memory-side bus of the SPRAM arbiter
interface mb8_arb_if #(
  parameter int N   = 2,
  parameter int DSZ = 8,
  parameter int ASZ = 17
);
  logic [N-1:0]     req;
  logic [N-1:0]     we;
  logic [N*ASZ-1:0] ai;
  logic [N*DSZ-1:0] vi;
  logic [N-1:0]     gnt;
  logic [N-1:0]     ack;
  logic [DSZ-1:0]   rdata;
  logic             mem_we;
  logic [ASZ-1:0]   mem_ai;
  logic [DSZ-1:0]   mem_vi;
  logic [DSZ-1:0]   mem_vo;
  modport slave (input req, we, ai, vi, mem_vo, output gnt, ack, rdata, mem_we, mem_ai, mem_vi);
  modport master(output req, we, ai, vi, mem_vo, input gnt, ack, rdata, mem_we, mem_ai, mem_vi);
endinterface

// File: rtl/mb8_arb.sv
// mb8_arb: round-robin SPRAM bus arbiter; define MB8_ARB_PRIO_EN to give requester 0 fixed priority
module mb8_arb #(
  parameter int N   = 2,
  parameter int DSZ = 8,
  parameter int ASZ = 17
) (
  input logic       clk,
  input logic       rst_n,
  mb8_arb_if.slave  bus
);
  localparam int LW = (N > 1) ? $clog2(N) : 1;
  logic [N-1:0]   gnt_q, gnt_d, ack_q, ack_d, elig, rr;
  logic           mem_we_q, mem_we_d, hit, prio_win;
  logic [ASZ-1:0] mem_ai_q, mem_ai_d;
  logic [DSZ-1:0] mem_vi_q, mem_vi_d;
  logic [LW-1:0]  last_q, last_d, w;
  int             idx;
  // pick the winner and form the next issue; the requester just granted sits out one cycle
  always_comb begin
    elig = bus.req & ~gnt_q;
    rr = elig;
    prio_win = 1'b0;
`ifdef MB8_ARB_PRIO_EN
    rr[0] = 1'b0;
    prio_win = elig[0];
`endif
    w = '0;
    hit = 1'b0;
    idx = 0;
    for (int i = 1; i <= N; i++) begin
      idx = int'(last_q) + i;
      if (idx >= N) idx = idx - N;
      if (!hit && rr[LW'(idx)]) begin
        hit = 1'b1;
        w = LW'(idx);
      end
    end
    if (prio_win) w = '0;
    gnt_d = |elig ? {{(N-1){1'b0}}, 1'b1} << w : '0;
    ack_d = gnt_q;
    last_d = (|elig && !prio_win) ? w : last_q;
    mem_we_d = |elig ? bus.we[w] : 1'b0;
    mem_ai_d = |elig ? bus.ai[int'(w)*ASZ +: ASZ] : mem_ai_q;
    mem_vi_d = |elig ? bus.vi[int'(w)*DSZ +: DSZ] : mem_vi_q;
  end
  // issue/ack registers; reset drops any access in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q <= '0;
      ack_q <= '0;
      mem_we_q <= 1'b0;
      mem_ai_q <= '0;
      mem_vi_q <= '0;
      last_q <= LW'(N - 1);
    end else begin
      gnt_q <= gnt_d;
      ack_q <= ack_d;
      mem_we_q <= mem_we_d;
      mem_ai_q <= mem_ai_d;
      mem_vi_q <= mem_vi_d;
      last_q <= last_d;
    end
  end
  assign bus.gnt = gnt_q;
  assign bus.ack = ack_q;
  assign bus.mem_we = mem_we_q;
  assign bus.mem_ai = mem_ai_q;
  assign bus.mem_vi = mem_vi_q;
  assign bus.rdata = bus.mem_vo;
endmodule

// File: tb/tb_mb8_arb.sv
// tb_mb8_arb: scoreboard bench for mb8_arb with a behavioural SPRAM
module tb_mb8_arb;
  typedef struct { logic [1:0] g; logic we; logic [16:0] a; logic [7:0] v; } gexp_t;
  typedef struct { logic [1:0] k; logic rd; logic [7:0] d; } aexp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pl_en = 1'b0;
  logic [16:0] pl_a = '0;
  logic [7:0] pl_v = '0;
  logic prev0 = 1'b0;
  logic [7:0] mem [0:(1<<17)-1];
  gexp_t gq[$];
  aexp_t aq[$];
  int nchk = 0;
  int nfail = 0;
  mb8_arb_if #(.N(2), .DSZ(8), .ASZ(17)) bus();
  mb8_arb #(.N(2), .DSZ(8), .ASZ(17)) dut(.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (pl_en) mem[pl_a] <= pl_v;
    else if (bus.mem_we) mem[bus.mem_ai] <= bus.mem_vi;
    bus.mem_vo <= mem[bus.mem_ai];
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic set_rq(input int k, input logic w, input logic [16:0] a, input logic [7:0] v);
    bus.we[k] = w;
    bus.ai[k*17 +: 17] = a;
    bus.vi[k*8 +: 8] = v;
  endtask
  task automatic push_g(input logic [1:0] g, input logic w, input logic [16:0] a, input logic [7:0] v);
    gq.push_back('{g: g, we: w, a: a, v: v});
  endtask
  task automatic push_a(input logic [1:0] k, input logic rd, input logic [7:0] d);
    aq.push_back('{k: k, rd: rd, d: d});
  endtask
  always @(negedge clk) begin
    gexp_t ge;
    aexp_t ae;
    if (rst_n) begin
      if (bus.mem_we) chk("we_outside_gnt", 32'(|bus.gnt), 32'd1);
      if (bus.gnt[0]) chk("gnt0_consecutive", 32'(prev0), 32'd0);
      prev0 = bus.gnt[0];
      if (bus.gnt != 2'b00) begin
        if (gq.size() == 0) chk("gnt_unexpected", 32'(bus.gnt), 32'd0);
        else begin
          ge = gq.pop_front();
          chk("gnt", 32'(bus.gnt), 32'(ge.g));
          chk("mem_we", 32'(bus.mem_we), 32'(ge.we));
          chk("mem_ai", 32'(bus.mem_ai), 32'(ge.a));
          if (ge.we) chk("mem_vi", 32'(bus.mem_vi), 32'(ge.v));
        end
      end
      if (bus.ack != 2'b00) begin
        if (aq.size() == 0) chk("ack_unexpected", 32'(bus.ack), 32'd0);
        else begin
          ae = aq.pop_front();
          chk("ack", 32'(bus.ack), 32'(ae.k));
          if (ae.rd) chk("rdata", 32'(bus.rdata), 32'(ae.d));
        end
      end
    end else prev0 = 1'b0;
  end
  initial begin
    logic [1:0] first, g;
    bus.req = '0;
    bus.we = '0;
    bus.ai = '0;
    bus.vi = '0;
    set_rq(0, 1'b0, 17'h00123, 8'h00);
    set_rq(1, 1'b0, 17'h1FFFF, 8'h00);
    bus.req = 2'b11;
    pl_en = 1'b1;
    pl_a = 17'h00123;
    pl_v = 8'hA5;
    @(negedge clk);
    pl_en = 1'b0;
    @(negedge clk);
    chk("rst_gnt", 32'(bus.gnt), 32'd0);
    chk("rst_ack", 32'(bus.ack), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_mem_ai", 32'(bus.mem_ai), 32'd0);
    chk("rst_mem_vi", 32'(bus.mem_vi), 32'd0);
    push_g(2'b01, 1'b0, 17'h00123, 8'h00);
    push_a(2'b01, 1'b1, 8'hA5);
    #1 rst_n = 1'b1;
    @(negedge clk);
    bus.req = 2'b00;
    repeat (2) @(negedge clk);
    set_rq(1, 1'b1, 17'h1FFFF, 8'h3C);
    bus.req = 2'b10;
    push_g(2'b10, 1'b1, 17'h1FFFF, 8'h3C);
    push_a(2'b10, 1'b0, 8'h00);
    @(negedge clk);
    bus.req = 2'b00;
    @(negedge clk);
    set_rq(1, 1'b0, 17'h1FFFF, 8'h00);
    bus.req = 2'b10;
    push_g(2'b10, 1'b0, 17'h1FFFF, 8'h00);
    push_a(2'b10, 1'b1, 8'h3C);
    @(negedge clk);
    bus.req = 2'b00;
    repeat (2) @(negedge clk);
    bus.req = 2'b01;
    push_g(2'b01, 1'b0, 17'h00123, 8'h00);
    push_a(2'b01, 1'b1, 8'hA5);
    @(negedge clk);
    bus.req = 2'b00;
    repeat (2) @(negedge clk);
`ifdef MB8_ARB_PRIO_EN
    first = 2'b01;
`else
    first = 2'b10;
`endif
    for (int i = 0; i < 4; i++) begin
      g = (i % 2 == 0) ? first : ~first;
      push_g(g, 1'b0, (g == 2'b01) ? 17'h00123 : 17'h1FFFF, 8'h00);
      push_a(g, 1'b1, (g == 2'b01) ? 8'hA5 : 8'h3C);
    end
    bus.req = 2'b11;
    repeat (4) @(negedge clk);
    bus.req = 2'b00;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      push_g(2'b01, 1'b0, 17'h00123, 8'h00);
      push_a(2'b01, 1'b1, 8'hA5);
    end
    bus.req = 2'b01;
    repeat (4) @(negedge clk);
    bus.req = 2'b00;
    repeat (2) @(negedge clk);
    set_rq(1, 1'b1, 17'h00055, 8'h77);
    bus.req = 2'b10;
    push_g(2'b10, 1'b1, 17'h00055, 8'h77);
    @(negedge clk);
    #1 rst_n = 1'b0;
    bus.req = 2'b00;
    @(negedge clk);
    chk("midrst_ack", 32'(bus.ack), 32'd0);
    chk("midrst_gnt", 32'(bus.gnt), 32'd0);
    chk("midrst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("midrst_mem_ai", 32'(bus.mem_ai), 32'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    bus.req = 2'b01;
    push_g(2'b01, 1'b0, 17'h00123, 8'h00);
    push_a(2'b01, 1'b1, 8'hA5);
    @(negedge clk);
    bus.req = 2'b00;
    for (int i = 0; i < 10 && (gq.size() != 0 || aq.size() != 0); i++) @(negedge clk);
    chk("gnt_queue_drained", 32'(gq.size()), 32'd0);
    chk("ack_queue_drained", 32'(aq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
